// File: rtl/comparator_pkg.sv
// Shared definitions for the registered comparator.
package comparator_pkg;

    localparam int CMP_WIDTH_DEFAULT = 3;

    // Encoded relation of x to y, computed ahead of the flag registers.
    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_GT,
        CMP_LT
    } cmp_result_e;

endpackage

// File: rtl/comparator_slice.sv
// One-bit compare cell: equality and strict greater-than for a single bit pair.
module comparator_slice (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt
);

    assign eq = ~(a ^ b);
    assign gt = a & ~b;

endmodule

// File: rtl/comparator.sv
// Registered unsigned comparator. The per-bit slices are folded MSB-first
// into a relation code, which is then captured in the output flag registers.
// Optional macro COMPARATOR_MAGNITUDE_EN adds the gto/lto flags and the
// one-hot check across all three flags.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             eqo
`ifdef COMPARATOR_MAGNITUDE_EN
    ,
    output logic             gto,
    output logic             lto
`endif
);

    logic [WIDTH-1:0] eq_bit;
    logic [WIDTH-1:0] gt_bit;
    cmp_result_e      res_d;
    logic             eq_run;
    logic             gt_run;
    logic             eqo_d, eqo_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        comparator_slice u_slice (
            .a  (x[i]),
            .b  (y[i]),
            .eq (eq_bit[i]),
            .gt (gt_bit[i])
        );
    end

    // Fold slices MSB-first: the highest differing bit decides the relation.
    always_comb begin
        eq_run = 1'b1;
        gt_run = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            gt_run = gt_run | (eq_run & gt_bit[i]);
            eq_run = eq_run & eq_bit[i];
        end
        if (eq_run)      res_d = CMP_EQ;
        else if (gt_run) res_d = CMP_GT;
        else             res_d = CMP_LT;
    end

    assign eqo_d = (res_d == CMP_EQ);
    assign eqo   = eqo_q;

`ifdef COMPARATOR_MAGNITUDE_EN
    logic gto_d, gto_q;
    logic lto_d, lto_q;
    logic vld_q;

    assign gto_d = (res_d == CMP_GT);
    assign lto_d = (res_d == CMP_LT);
    assign gto   = gto_q;
    assign lto   = lto_q;

    // Flag registers; reset clears them at once, discarding any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eqo_q <= 1'b0;
            gto_q <= 1'b0;
            lto_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            eqo_q <= eqo_d;
            gto_q <= gto_d;
            lto_q <= lto_d;
            vld_q <= 1'b1;
        end
    end

    // Once a real result has been captured, exactly one flag must be high.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        vld_q |-> $onehot({eqo_q, gto_q, lto_q}));
`else
    // Equality register; reset clears it at once, discarding any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) eqo_q <= 1'b0;
        else        eqo_q <= eqo_d;
    end
`endif

    // Unknown operand bits would silently resolve in the compare; flag them.
    a_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({x, y}));

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed boundary/reset steps plus
// random operands scored against integer relational arithmetic.
module tb_comparator;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         eqo;
`ifdef COMPARATOR_MAGNITUDE_EN
    logic         gto;
    logic         lto;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Flags expected to be showing right now (before the next edge).
    logic pe, pg, pl;

    comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .eqo   (eqo)
`ifdef COMPARATOR_MAGNITUDE_EN
        ,
        .gto   (gto),
        .lto   (lto)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e, input logic g, input logic l);
        chk({tag, "_eq"}, eqo, e);
`ifdef COMPARATOR_MAGNITUDE_EN
        chk({tag, "_gt"}, gto, g);
        chk({tag, "_lt"}, lto, l);
`else
        if (g === 1'bx || l === 1'bx) $display("note: %s magnitude unknown", tag);
`endif
    endtask

    // Apply operands just after an edge, confirm outputs hold, then check
    // the result one edge later against plain integer comparison.
    task automatic step(input int xv, input int yv, input string tag);
        int a, b;
        a = xv;
        b = yv;
        x = a[W-1:0];
        y = b[W-1:0];
        #1;
        chk_all({tag, "_hold"}, pe, pg, pl);
        @(posedge clk);
        #1;
        pe = (a == b);
        pg = (a > b);
        pl = (a < b);
        chk_all(tag, pe, pg, pl);
    endtask

    initial begin
        rst_n = 1'b0;
        x     = 3'b100;
        y     = 3'b100;

        // Held in reset with matching operands: nothing shows.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all("rst_hold", 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("rel_noedge", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("rel_first", 1'b1, 1'b0, 1'b0);
        pe = 1'b1; pg = 1'b0; pl = 1'b0;

        step(0, 0, "zero_zero");
        step(1, 2, "one_two");
        step(4, 4, "eq_after_mis");
        step(7, 0, "ones_zero");
        step(3, 7, "three_ones");
        step(7, 7, "ones_ones");
        step(4, 0, "msb_only");
        step(1, 0, "lsb_only");
        step(0, 4, "msb_only_r");
        step(6, 7, "lsb_only_r");

        for (int i = 0; i < 200; i++) begin
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rand");
        end

        // Mid-cycle reset pulse while eqo is high.
        step(5, 5, "pre_pulse");
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("pulse_async", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("pulse_held", 1'b0, 1'b0, 1'b0);
        // New operands before release; the old match must not reappear.
        x = 3'b010;
        y = 3'b110;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("pulse_rel", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        pe = 1'b0; pg = 1'b0; pl = 1'b1;
        chk_all("pulse_first", pe, pg, pl);
        step(2, 2, "post_pulse");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
